descriptor_mem_arbiter: RTL

- Two-master arbiter in front of the single-port 1024×32 descriptor RAM.
- Shares the RAM between the Nios II data master (port 0) and the scatter-gather DMA descriptor master (port 1), one transfer per cycle.
- Uses round-robin arbitration with a bounded grant hold, so the DMA can fetch a whole 8-word descriptor without interleaving.
- Tracks the RAM's fixed one-cycle read latency and routes `readdatavalid` back to the issuing master.

---
 rtl/descriptor_mem_arbiter_if.sv | 24 ++
 rtl/descriptor_mem_arbiter.sv | 104 ++++++++++
 2 files changed

// File: rtl/descriptor_mem_arbiter_if.sv
// One Avalon-style master port of the descriptor RAM arbiter.
interface descriptor_mem_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   address;
  logic                read;
  logic                write;
  logic [DATA_W/8-1:0] byteenable;
  logic [DATA_W-1:0]   writedata;
  logic                waitrequest;
  logic [DATA_W-1:0]   readdata;
  logic                readdatavalid;

  modport master (
    output address, read, write, byteenable, writedata,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, read, write, byteenable, writedata,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/descriptor_mem_arbiter.sv
// Two-master arbiter for the single-port descriptor RAM: round-robin with a bounded grant hold.
// Define DESC_ARB_FIXED_PRIO_EN to give port 1 (DMA) fixed priority; the hold counter is then removed.
module descriptor_mem_arbiter #(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 32,
  parameter int HOLD_MAX = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  descriptor_mem_arbiter_if.slave m0,
  descriptor_mem_arbiter_if.slave m1,
  output logic [ADDR_W-1:0]       mem_address,
  output logic [DATA_W/8-1:0]     mem_byteenable,
  output logic [DATA_W-1:0]       mem_writedata,
  output logic                    mem_chipselect,
  output logic                    mem_write,
  output logic                    mem_clken,
  input  logic [DATA_W-1:0]       mem_readdata
);

  logic req0, req1;
  logic grant0, grant1;
  logic rd_pend_q, rd_pend_d;
  logic rd_id_q, rd_id_d;

  assign req0 = m0.read | m0.write;
  assign req1 = m1.read | m1.write;

`ifdef DESC_ARB_FIXED_PRIO_EN
  always_comb begin
    grant1 = ~reset & req1;
    grant0 = ~reset & req0 & ~req1;
  end
`else
  localparam logic [3:0] HOLD_LIM = 4'(HOLD_MAX);

  logic       owner_q, owner_d;
  logic [3:0] hold_cnt_q, hold_cnt_d;
  logic       tie_win;

  // A zero count means the owner has no live run (idle cycle or reset), so a tie rotates.
  always_comb begin
    tie_win = ((hold_cnt_q == 4'd0) || (hold_cnt_q == HOLD_LIM)) ? ~owner_q : owner_q;
    grant1  = ~reset & req1 & (~req0 | tie_win);
    grant0  = ~reset & req0 & (~req1 | ~tie_win);
  end

  always_comb begin
    owner_d    = owner_q;
    hold_cnt_d = 4'd0;
    if (grant0 | grant1) begin
      if (grant1 == owner_q) begin
        hold_cnt_d = (hold_cnt_q == HOLD_LIM) ? HOLD_LIM : hold_cnt_q + 4'd1;
      end else begin
        owner_d    = grant1;
        hold_cnt_d = 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q    <= 1'b1;
      hold_cnt_q <= 4'd0;
    end else begin
      owner_q    <= owner_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end
`endif

  always_comb begin
    rd_pend_d = (grant0 & m0.read) | (grant1 & m1.read);
    rd_id_d   = grant1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_pend_q <= 1'b0;
      rd_id_q   <= 1'b0;
    end else begin
      rd_pend_q <= rd_pend_d;
      rd_id_q   <= rd_id_d;
    end
  end

  always_comb begin
    mem_address    = grant1 ? m1.address    : m0.address;
    mem_byteenable = grant1 ? m1.byteenable : m0.byteenable;
    mem_writedata  = grant1 ? m1.writedata  : m0.writedata;
    mem_chipselect = grant0 | grant1;
    mem_write      = (grant0 & m0.write) | (grant1 & m1.write);
    mem_clken      = ~reset;
  end

  assign m0.waitrequest   = reset | (req0 & ~grant0);
  assign m1.waitrequest   = reset | (req1 & ~grant1);
  // Gated by reset so a read accepted just before reset never reports back.
  assign m0.readdatavalid = ~reset & rd_pend_q & ~rd_id_q;
  assign m1.readdatavalid = ~reset & rd_pend_q &  rd_id_q;
  assign m0.readdata      = mem_readdata;
  assign m1.readdata      = mem_readdata;

endmodule
